// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to instruction
// memory and queues returned words with their PCs in a small circular buffer for decode.
module instr_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    logic [31:0]      fetchPc;
    logic [31:0]      reqPc;
    logic             outstanding;
    logic             drop;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [31:0]      instrMem [DEPTH];
    logic [31:0]      pcMem    [DEPTH];

    logic             reqFire;
    logic             rspFire;
    logic             push;
    logic             pop;
    logic             headValid;
    logic [CNT_W:0]   inUse;
    logic             unusedPcBits;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Every in-flight request holds a buffer slot, so a response can always be pushed.
    assign inUse          = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    assign imem_req_valid = !redirect_valid && (!outstanding || imem_rsp_valid) && (inUse < DEPTH_C);
    assign imem_addr      = fetchPc;

    assign reqFire   = imem_req_valid && imem_req_ready;
    assign rspFire   = imem_rsp_valid && outstanding;
    assign headValid = (count != '0);
    assign push      = rspFire && !drop && !redirect_valid;
    assign pop       = headValid && id_ready && !redirect_valid;

    assign unusedPcBits = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetchPc <= {redirect_pc[31:2], 2'b00};
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            // A response still owed by memory must be swallowed when it finally shows up.
            if (outstanding && !imem_rsp_valid) begin
                drop <= 1'b1;
            end else begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
        end else begin
            if (reqFire) begin
                fetchPc     <= fetchPc + 32'd4;
                outstanding <= 1'b1;
            end else if (rspFire) begin
                outstanding <= 1'b0;
            end
            if (rspFire) begin
                drop <= 1'b0;
            end
            if (push) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reqFire) begin
            reqPc <= fetchPc;
        end
        if (push) begin
            instrMem[wrPtr] <= imem_rsp_data;
            pcMem[wrPtr]    <= reqPc;
        end
    end

    assign if_valid    = headValid;
    assign if_instr    = headValid ? instrMem[rdPtr] : NOP;
    assign if_pc       = headValid ? pcMem[rdPtr] : 32'h0;
    assign if_pc_plus4 = headValid ? pcMem[rdPtr] + 32'd4 : 32'h0;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: scripted memory returning addr>>2,
// with per-scenario tasks checking fetch order, stalls, redirects, wrap and reset.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int nChecks = 0;
    int nPass   = 0;
    logic memAuto = 1'b0;

    instr_fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(3)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .id_ready(id_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    always #5 clk = ~clk;

    // One clock cycle; with memAuto set, a handshake is answered the next cycle with addr>>2.
    task automatic tick();
        logic        hs;
        logic [31:0] hsAddr;
        #1;
        hs     = memAuto && !rst && imem_req_valid && imem_req_ready;
        hsAddr = imem_addr;
        @(posedge clk);
        #1;
        if (memAuto) begin
            imem_rsp_valid = hs;
            imem_rsp_data  = hsAddr >> 2;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; memAuto = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; memAuto = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        tick(); tick();
        nChecks++; if (imem_req_valid !== 1'b1) $display("FAIL reset_req_valid: got %b want 1", imem_req_valid); else nPass++;
        nChecks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", imem_addr); else nPass++;
        nChecks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid); else nPass++;
        nChecks++; if (if_instr !== 32'h13) $display("FAIL reset_if_instr: got %h want 00000013", if_instr); else nPass++;
        nChecks++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) $display("FAIL reset_if_pc: got %h/%h want 0/0", if_pc, if_pc_plus4); else nPass++;
        redirect_valid = 1'b1;
        #1;
        nChecks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_blocked_by_redirect: got %b want 0", imem_req_valid); else nPass++;
        redirect_valid = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_stream();
        memAuto = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nChecks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'(4 * k))
                $display("FAIL stream_req[%0d]: got v=%b addr=%h want v=1 addr=%h", k, imem_req_valid, imem_addr, 32'(4 * k));
            else nPass++;
            if (k < 2) begin
                nChecks++; if (if_valid !== 1'b0) $display("FAIL stream_early_valid[%0d]: got %b want 0", k, if_valid); else nPass++;
            end else begin
                nChecks++;
                if (if_valid !== 1'b1 || if_instr !== 32'(k - 2) || if_pc !== 32'(4 * (k - 2)) || if_pc_plus4 !== 32'(4 * (k - 1)))
                    $display("FAIL stream_head[%0d]: got v=%b i=%h pc=%h p4=%h want v=1 i=%h pc=%h p4=%h",
                             k, if_valid, if_instr, if_pc, if_pc_plus4, 32'(k - 2), 32'(4 * (k - 2)), 32'(4 * (k - 1)));
                else nPass++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int expN;
        int got;
        id_ready = 1'b0;
        repeat (10) tick();
        nChecks++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); else nPass++;
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'd6) $display("FAIL stall_head: got v=%b i=%h want v=1 i=00000006", if_valid, if_instr); else nPass++;
        id_ready = 1'b1;
        expN = 6;
        got  = 0;
        for (int c = 0; c < 16 && got < 8; c++) begin
            if (if_valid === 1'b1) begin
                nChecks++;
                if (if_instr !== 32'(expN) || if_pc !== 32'(4 * expN))
                    $display("FAIL drain_order[%0d]: got i=%h pc=%h want i=%h pc=%h", got, if_instr, if_pc, 32'(expN), 32'(4 * expN));
                else nPass++;
                expN++;
                got++;
            end
            tick();
        end
        nChecks++; if (got !== 8) $display("FAIL drain_timeout: got %0d instrs want 8", got); else nPass++;
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        memAuto = 1'b1;
        repeat (8) tick();
        nChecks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h20) $display("FAIL redir_setup: got v=%b addr=%h want v=1 addr=00000020", imem_req_valid, imem_addr); else nPass++;
        memAuto = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        nChecks++; if (imem_req_valid !== 1'b0) $display("FAIL redir_no_req: got %b want 0", imem_req_valid); else nPass++;
        tick();
        redirect_valid = 1'b0;
        #1;
        nChecks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL redir_wait: got v=%b req=%b want 0/0", if_valid, imem_req_valid); else nPass++;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; memAuto = 1'b1;
        #1;
        nChecks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) $display("FAIL redir_new_req: got v=%b addr=%h want v=1 addr=00000100", imem_req_valid, imem_addr); else nPass++;
        nChecks++; if (if_valid !== 1'b0) $display("FAIL redir_stale_vis0: got %b want 0", if_valid); else nPass++;
        tick();
        nChecks++; if (if_valid !== 1'b0) $display("FAIL redir_stale_vis1: got v=%b i=%h want v=0", if_valid, if_instr); else nPass++;
        tick();
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'h40 || if_pc !== 32'h100) $display("FAIL redir_target: got v=%b i=%h pc=%h want v=1 i=00000040 pc=00000100", if_valid, if_instr, if_pc); else nPass++;
    endtask

    task automatic test_redirect_rsp_pop();
        id_ready = 1'b0;
        tick();
        nChecks++; if (imem_rsp_valid !== 1'b1 || if_valid !== 1'b1 || imem_req_valid !== 1'b0) $display("FAIL rrp_setup: got rsp=%b v=%b req=%b want 1/1/0", imem_rsp_valid, if_valid, imem_req_valid); else nPass++;
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        nChecks++; if (imem_req_valid !== 1'b0) $display("FAIL rrp_no_req: got %b want 0", imem_req_valid); else nPass++;
        tick();
        redirect_valid = 1'b0;
        #1;
        nChecks++; if (if_valid !== 1'b0) $display("FAIL rrp_empty: got %b want 0", if_valid); else nPass++;
        nChecks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rrp_resume: got v=%b addr=%h want v=1 addr=00000200", imem_req_valid, imem_addr); else nPass++;
        tick();
        tick();
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'h80 || if_pc !== 32'h200) $display("FAIL rrp_target: got v=%b i=%h pc=%h want v=1 i=00000080 pc=00000200", if_valid, if_instr, if_pc); else nPass++;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        memAuto = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        nChecks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req0: got v=%b addr=%h want v=1 addr=fffffffc", imem_req_valid, imem_addr); else nPass++;
        tick();
        nChecks++; if (imem_addr !== 32'h0) $display("FAIL wrap_req1: got %h want 00000000", imem_addr); else nPass++;
        tick();
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'h3FFF_FFFF || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0)
            $display("FAIL wrap_head0: got v=%b i=%h pc=%h p4=%h want v=1 i=3fffffff pc=fffffffc p4=00000000", if_valid, if_instr, if_pc, if_pc_plus4); else nPass++;
        tick();
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h4)
            $display("FAIL wrap_head1: got v=%b i=%h pc=%h p4=%h want v=1 i=0 pc=0 p4=4", if_valid, if_instr, if_pc, if_pc_plus4); else nPass++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        memAuto = 1'b1; id_ready = 1'b0;
        tick(); tick();
        memAuto = 1'b0;
        tick();
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'h0 || imem_req_valid !== 1'b0) $display("FAIL midrst_setup: got v=%b i=%h req=%b want 1/0/0", if_valid, if_instr, imem_req_valid); else nPass++;
        rst = 1'b1;
        #1;
        nChecks++; if (if_valid !== 1'b0 || if_instr !== 32'h13 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL midrst_async: got v=%b i=%h req=%b addr=%h want 0/00000013/1/0", if_valid, if_instr, imem_req_valid, imem_addr); else nPass++;
        tick();
        rst = 1'b0; id_ready = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0BAD; memAuto = 1'b1;
        #1;
        tick();
        nChecks++; if (if_valid !== 1'b0) $display("FAIL midrst_late_rsp: got v=%b i=%h want v=0", if_valid, if_instr); else nPass++;
        tick();
        nChecks++; if (if_valid !== 1'b1 || if_instr !== 32'h0 || if_pc !== 32'h0) $display("FAIL midrst_refetch: got v=%b i=%h pc=%h want 1/0/0", if_valid, if_instr, if_pc); else nPass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_rsp_pop();
        test_pc_wrap();
        test_reset_midop();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
